// File: rtl/ll_reservation_unit.sv
// ll_reservation_unit
//   Multi-channel LL/SC reservation tracker, the successor to the single LLbit
//   register. Each channel holds a valid bit plus a granule-aligned address tag.
//   LL sets a reservation and SC checks and consumes it. A flush or a conflicting
//   committed store clears it.
//
// Optional feature (macro LLBIT_TIMEOUT_EN):
//   When the macro is defined, each channel gets a down-counter that is loaded
//   with TIMEOUT_CYCLES on LL. The reservation drops on the cycle the counter
//   reaches zero, which guarantees forward progress. When the macro is
//   undefined, reservations persist until flush, SC, snoop or reset.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   flush        per-channel flush, clears that channel's reservation
//   ll_we/ll_ch/ll_addr    LL commit strobe, channel, address
//   sc_req/sc_ch/sc_addr   SC commit strobe, channel, address
//   sc_ok        SC success (combinational, evaluated on pre-clock state)
//   st_valid/st_addr       committed store snoop, applies to every channel
//   llbit_o      registered per-channel valid bits for CP0 readout
module ll_reservation_unit #(
  parameter int NUM_CH         = 2,
  parameter int CH_W           = 1,
  parameter int ADDR_W         = 32,
  parameter int GRAN_LOG2      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] flush,
  input  logic              ll_we,
  input  logic [CH_W-1:0]   ll_ch,
  input  logic [ADDR_W-1:0] ll_addr,
  input  logic              sc_req,
  input  logic [CH_W-1:0]   sc_ch,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_ok,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  output logic [NUM_CH-1:0] llbit_o
);

  localparam int TAG_W = ADDR_W - GRAN_LOG2;

  logic [NUM_CH-1:0]            valid;
  logic [NUM_CH-1:0][TAG_W-1:0] tag;

  // Granule tags of the three incoming addresses
  logic [TAG_W-1:0] ll_tag, sc_tag, st_tag;
  assign ll_tag = ll_addr[ADDR_W-1:GRAN_LOG2];
  assign sc_tag = sc_addr[ADDR_W-1:GRAN_LOG2];
  assign st_tag = st_addr[ADDR_W-1:GRAN_LOG2];

  // Byte-offset bits inside a granule never take part in a compare
  generate
    if (GRAN_LOG2 > 0) begin : g_low
      logic unused_low;
      assign unused_low = ^{ll_addr[GRAN_LOG2-1:0], sc_addr[GRAN_LOG2-1:0],
                            st_addr[GRAN_LOG2-1:0]};
    end
  endgenerate

  // SC result uses the state before the clock edge. Same-cycle LL or snoop
  // updates are deliberately not bypassed into it. If sc_ch is out of range,
  // no loop index matches and the result is 0.
  always_comb begin
    sc_ok = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sc_req && (sc_ch == CH_W'(c)) && valid[c] && (tag[c] == sc_tag))
        sc_ok = 1'b1;
    end
  end

  assign llbit_o = valid;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic             v_q;
      logic [TAG_W-1:0] tag_q;
      logic             ll_hit, sc_hit, st_hit;

      assign ll_hit = ll_we  && (ll_ch == CH_W'(c));
      assign sc_hit = sc_req && (sc_ch == CH_W'(c));
      assign st_hit = st_valid && v_q && (tag_q == st_tag);

`ifdef LLBIT_TIMEOUT_EN
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          tag_q <= '0;
          cnt_q <= '0;
        end else if (flush[c]) begin
          v_q   <= 1'b0;
          cnt_q <= '0;
        end else if (ll_hit) begin
          v_q   <= 1'b1;
          tag_q <= ll_tag;
          cnt_q <= CNT_W'(TIMEOUT_CYCLES);
        end else if (sc_hit || st_hit) begin
          v_q   <= 1'b0;
        end else if (v_q) begin
          // The reservation drops on the same edge where the count reaches 0
          if (cnt_q <= CNT_W'(1)) begin
            v_q   <= 1'b0;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      end
`else
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q   <= 1'b0;
          tag_q <= '0;
        end else if (flush[c]) begin
          v_q   <= 1'b0;
        end else if (ll_hit) begin
          v_q   <= 1'b1;
          tag_q <= ll_tag;
        end else if (sc_hit || st_hit) begin
          // SC consumes the reservation whether it passed or failed
          v_q   <= 1'b0;
        end
      end
`endif

      assign valid[c] = v_q;
      assign tag[c]   = tag_q;
    end
  endgenerate

endmodule
